// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: request/response bundle between two requesters, the arbiter and its consumer
interface addsub_arbiter_if #(parameter int dw = 8);
  logic          req0_valid, req0_ready, req0_add_sub;
  logic          req1_valid, req1_ready, req1_add_sub;
  logic [dw-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [dw-1:0] rsp_result;
  modport master (
    output req0_valid, req0_a, req0_b, req0_add_sub,
    output req1_valid, req1_a, req1_b, req1_add_sub,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_result, rsp_id
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_add_sub,
    input  req1_valid, req1_a, req1_b, req1_add_sub,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_result, rsp_id
  );
endinterface

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one add/subtract datapath between two requesters
module addsub_arbiter #(
  parameter int dw = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_arbiter_if.slave      bus,
  output logic [7:0]           grant_cnt0,
  output logic [7:0]           grant_cnt1
);
  logic          rsp_valid, rsp_id, rr_last;
  logic [dw-1:0] rsp_result;
  logic          free, winner, rdy0, rdy1, accept, add_sub;
  logic [dw-1:0] a, b, res;
  // gating with rst_n keeps both ready outputs low while reset is held
  assign free    = rst_n & (~rsp_valid | bus.rsp_ready);
  assign winner  = (bus.req0_valid & bus.req1_valid) ? ~rr_last : bus.req1_valid;
  assign rdy0    = free & ~winner & bus.req0_valid;
  assign rdy1    = free & winner & bus.req1_valid;
  assign accept  = rdy0 | rdy1;
  assign a       = winner ? bus.req1_a : bus.req0_a;
  assign b       = winner ? bus.req1_b : bus.req0_b;
  assign add_sub = winner ? bus.req1_add_sub : bus.req0_add_sub;
  assign res     = add_sub ? a + b : a - b;
  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_id     = rsp_id;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      rr_last    <= 1'b1;
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_result <= res;
      rsp_id     <= winner;
      rr_last    <= winner;
      grant_cnt0 <= grant_cnt0 + {7'd0, rdy0};
      grant_cnt1 <= grant_cnt1 + {7'd0, rdy1};
    end else if (bus.rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: randomized scenarios checked against a behavioural arbiter model
module tb_addsub_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] grant_cnt0, grant_cnt1;
  int         total = 0, passed = 0;
  int         m_valid, m_result, m_id, m_last, m_cnt0, m_cnt1;

  addsub_arbiter_if #(.dw(8)) bus ();
  addsub_arbiter #(.dw(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0; m_result = 0; m_id = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // -1 = nobody granted this cycle
  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_valid != 0 && !bus.rsp_ready) return -1;
    if (bus.req0_valid && bus.req1_valid) return m_last == 0 ? 1 : 0;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  task automatic tick();
    int g, x, y;
    g = exp_grant();
    @(posedge clk);
    if (g >= 0) begin
      x = (g == 0) ? int'(bus.req0_a) : int'(bus.req1_a);
      y = (g == 0) ? int'(bus.req0_b) : int'(bus.req1_b);
      m_result = (((g == 0) ? bus.req0_add_sub : bus.req1_add_sub) ? x + y : x - y + 256) % 256;
      m_valid = 1; m_id = g; m_last = g;
      if (g == 0) m_cnt0 = (m_cnt0 + 1) % 256; else m_cnt1 = (m_cnt1 + 1) % 256;
    end else if (m_valid != 0 && bus.rsp_ready) m_valid = 0;
    #1;
  endtask

  task automatic drive(input bit v0, input int a0, input int b0, input bit s0,
                       input bit v1, input int a1, input int b1, input bit s1, input bit rr);
    bus.req0_valid = v0; bus.req0_a = 8'(a0); bus.req0_b = 8'(b0); bus.req0_add_sub = s0;
    bus.req1_valid = v1; bus.req1_a = 8'(a1); bus.req1_b = 8'(b1); bus.req1_add_sub = s1;
    bus.rsp_ready = rr;
    #1;
  endtask

  task automatic test_reset();
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 8'd0 || bus.rsp_id !== 1'b0)
      $display("FAIL reset_outputs valid=%b result=%h id=%b want 0/00/0", bus.rsp_valid, bus.rsp_result, bus.rsp_id); else passed++;
    total++; if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0)
      $display("FAIL reset_counts cnt0=%0d cnt1=%0d want 0/0", grant_cnt0, grant_cnt1); else passed++;
    drive(1, 10, 5, 1, 0, 0, 0, 0, 0);
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'd15)
      $display("FAIL pending_before_reset valid=%b result=%0d want 1/15", bus.rsp_valid, bus.rsp_result); else passed++;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 8'd0 || bus.rsp_id !== 1'b0 || grant_cnt0 !== 8'd0)
      $display("FAIL async_reset valid=%b result=%h id=%b cnt0=%0d want all 0", bus.rsp_valid, bus.rsp_result, bus.rsp_id, grant_cnt0); else passed++;
    bus.rsp_ready = 1'b1; #1;
    total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
      $display("FAIL ready_in_reset r0=%b r1=%b want 0/0", bus.req0_ready, bus.req1_ready); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1, 1, 2, 1, 1, 3, 4, 1, 1);
    total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL first_contest r0=%b r1=%b want 1/0", bus.req0_ready, bus.req1_ready); else passed++;
    tick();
    total++; if (bus.rsp_id !== 1'b0 || bus.rsp_result !== 8'd3)
      $display("FAIL first_contest_rsp id=%b result=%0d want 0/3", bus.rsp_id, bus.rsp_result); else passed++;
  endtask

  task automatic test_single_add();
    drive(1, 20, 22, 1, 0, 0, 0, 0, 1);
    total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL add_ready r0=%b r1=%b want 1/0", bus.req0_ready, bus.req1_ready); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'd42 || bus.rsp_id !== 1'b0)
      $display("FAIL add_rsp valid=%b result=%0d id=%b want 1/42/0", bus.rsp_valid, bus.rsp_result, bus.rsp_id); else passed++;
    bus.rsp_ready = 1'b1; #1;
    tick();
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 8'd42)
      $display("FAIL drain_only valid=%b result=%0d want 0/42", bus.rsp_valid, bus.rsp_result); else passed++;
  endtask

  task automatic test_sub_wrap();
    drive(0, 0, 0, 0, 1, 3, 5, 0, 1);
    tick();
    total++; if (bus.rsp_result !== 8'hFE || bus.rsp_id !== 1'b1)
      $display("FAIL sub_wrap result=%h id=%b want fe/1", bus.rsp_result, bus.rsp_id); else passed++;
    drive(0, 0, 0, 0, 1, 255, 1, 1, 1);
    tick();
    total++; if (bus.rsp_result !== 8'h00 || bus.rsp_id !== 1'b1)
      $display("FAIL add_wrap result=%h id=%b want 00/1", bus.rsp_result, bus.rsp_id); else passed++;
    drive(1, 0, 1, 0, 0, 0, 0, 0, 1);
    tick();
    total++; if (bus.rsp_result !== 8'hFF || bus.rsp_id !== 1'b0)
      $display("FAIL zero_minus_one result=%h id=%b want ff/0", bus.rsp_result, bus.rsp_id); else passed++;
  endtask

  task automatic test_contention();
    int c0, c1, g;
    c0 = m_cnt0; c1 = m_cnt1;
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom_range(255), $urandom_range(255), 1'($urandom), 1, $urandom_range(255), $urandom_range(255), 1'($urandom), 1);
      g = exp_grant();
      total++; if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1) || g != ((m_last + 1) % 2))
        $display("FAIL contend_grant%0d r0=%b r1=%b want grant %0d", i, bus.req0_ready, bus.req1_ready, g); else passed++;
      tick();
      total++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_result) != m_result || int'(bus.rsp_id) != m_id)
        $display("FAIL contend_rsp%0d result=%0d id=%b want %0d/%0d", i, bus.rsp_result, bus.rsp_id, m_result, m_id); else passed++;
    end
    total++; if (int'(grant_cnt0) != (c0 + 2) % 256 || int'(grant_cnt1) != (c1 + 2) % 256)
      $display("FAIL contend_counts cnt0=%0d cnt1=%0d want %0d/%0d", grant_cnt0, grant_cnt1, (c0 + 2) % 256, (c1 + 2) % 256); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] held_r;
    logic       held_id;
    held_r = bus.rsp_result; held_id = bus.rsp_id;
    for (int i = 0; i < 3; i++) begin
      drive(1, 100 + i, 7, 1, 1, 50, i, 0, 0);
      total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
        $display("FAIL bp_ready%0d r0=%b r1=%b want 0/0", i, bus.req0_ready, bus.req1_ready); else passed++;
      tick();
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== held_r || bus.rsp_id !== held_id)
        $display("FAIL bp_stable%0d result=%h id=%b want %h/%b", i, bus.rsp_result, bus.rsp_id, held_r, held_id); else passed++;
    end
    bus.rsp_ready = 1'b1; #1;
    total++; if ((bus.req0_ready ^ bus.req1_ready) !== 1'b1)
      $display("FAIL bp_release r0=%b r1=%b want exactly one", bus.req0_ready, bus.req1_ready); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_result) != m_result || int'(bus.rsp_id) != m_id)
      $display("FAIL bp_replace valid=%b result=%0d id=%b want 1/%0d/%0d", bus.rsp_valid, bus.rsp_result, bus.rsp_id, m_result, m_id); else passed++;
  endtask

  task automatic test_random();
    int g, bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), $urandom_range(255), $urandom_range(255), 1'($urandom),
            1'($urandom), $urandom_range(255), $urandom_range(255), 1'($urandom), ($urandom_range(3) != 0));
      g = exp_grant();
      total++; if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
        if (bad++ < 10) $display("FAIL rand_grant%0d r0=%b r1=%b want grant %0d", i, bus.req0_ready, bus.req1_ready, g);
      end else passed++;
      tick();
      total++; if (int'(bus.rsp_valid) != m_valid || (m_valid != 0 && (int'(bus.rsp_result) != m_result || int'(bus.rsp_id) != m_id))) begin
        if (bad++ < 10) $display("FAIL rand_rsp%0d valid=%b result=%0d id=%b want %0d/%0d/%0d", i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, m_valid, m_result, m_id);
      end else passed++;
      total++; if (int'(grant_cnt0) != m_cnt0 || int'(grant_cnt1) != m_cnt1) begin
        if (bad++ < 10) $display("FAIL rand_cnt%0d cnt0=%0d cnt1=%0d want %0d/%0d", i, grant_cnt0, grant_cnt1, m_cnt0, m_cnt1);
      end else passed++;
    end
  endtask

  task automatic test_counter_wrap();
    int c0, c1;
    c0 = m_cnt0; c1 = m_cnt1;
    for (int i = 0; i < 256; i++) begin
      drive(1, $urandom_range(255), $urandom_range(255), 1'($urandom), 0, 0, 0, 0, 1);
      tick();
      if (i == 127) begin
        total++; if (int'(grant_cnt0) != m_cnt0)
          $display("FAIL wrap_mid cnt0=%0d want %0d", grant_cnt0, m_cnt0); else passed++;
      end
    end
    total++; if (int'(grant_cnt0) != c0 || int'(grant_cnt1) != c1)
      $display("FAIL wrap_end cnt0=%0d cnt1=%0d want %0d/%0d", grant_cnt0, grant_cnt1, c0, c1); else passed++;
    total++; if (int'(bus.rsp_result) != m_result || bus.rsp_id !== 1'b0)
      $display("FAIL wrap_last result=%0d id=%b want %0d/0", bus.rsp_result, bus.rsp_id, m_result); else passed++;
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single_add();
    test_sub_wrap();
    test_contention();
    test_back_to_back();
    test_random();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
